// File: rtl/m72_bus_pkg.sv
// rtl/m72_bus_pkg.sv - shared types and M72 address-map constants for the bus region decoder
package m72_bus_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACTIVE} bus_state_t;

    localparam int MAX_REGIONS = 16;

    // M72 memory windows (20-bit V30 physical addresses)
    localparam logic [19:0] M72_ROM0_BASE    = 20'h00000, M72_ROM0_MASK    = 20'hC0000;
    localparam logic [19:0] M72_ROM1_BASE    = 20'h40000, M72_ROM1_MASK    = 20'hC0000;
    localparam logic [19:0] M72_RAM_BASE     = 20'hA0000, M72_RAM_MASK     = 20'hFC000;
    localparam logic [19:0] M72_OBJ_P_BASE   = 20'hC0000, M72_OBJ_P_MASK   = 20'hFC000;
    localparam logic [19:0] M72_CHARA_P_BASE = 20'hC8000, M72_CHARA_P_MASK = 20'hFC000;
    localparam logic [19:0] M72_CHARA_BASE   = 20'hD0000, M72_CHARA_MASK   = 20'hFC000;
    localparam logic [19:0] M72_SOUND_BASE   = 20'hE0000, M72_SOUND_MASK   = 20'hFF000;

    // M72 I/O port windows
    localparam logic [19:0] M72_IO_CTRL_BASE = 20'h00000, M72_IO_CTRL_MASK = 20'h000C0;
    localparam logic [19:0] M72_IO_PORT_BASE = 20'h00040, M72_IO_PORT_MASK = 20'h000C0;

endpackage

// File: rtl/region_match.sv
// rtl/region_match.sv - combinational base/mask window match with lowest-index priority encode
module region_match #(
    parameter int ADDR_W      = 20,
    parameter int NUM_REGIONS = 8,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_MASK = '0,
    parameter logic [NUM_REGIONS-1:0]             REGION_IO   = '0
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic                   m_io,
    output logic [NUM_REGIONS-1:0] match,
    output logic [3:0]             idx
);

    always_comb begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
            match[i] = (((addr ^ REGION_BASE[i]) & REGION_MASK[i]) == '0) && (m_io != REGION_IO[i]);
        end
    end

    // Scan downwards so the lowest matching index is the last one written
    always_comb begin
        idx = 4'd0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (match[i]) idx = 4'(i);
        end
    end

endmodule

// File: rtl/bus_region_decoder.sv
// rtl/bus_region_decoder.sv - registered chip-select decoder with per-region wait-state insertion
module bus_region_decoder
    import m72_bus_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int NUM_REGIONS = 8,
    parameter int WS_W        = 3,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_MASK = '0,
    parameter logic [NUM_REGIONS-1:0]             REGION_IO   = '0,
    parameter logic [NUM_REGIONS-1:0][WS_W-1:0]   REGION_WS   = '0,
    parameter int MISS_WS     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    input  logic                   bus_start,
    input  logic                   bus_end,
    input  logic [ADDR_W-1:0]      addr,
    input  logic                   m_io,
    output logic [NUM_REGIONS-1:0] cs,
    output logic [3:0]             region_idx,
    output logic                   hit,
    output logic                   ready,
    output logic                   busy
);

    if (NUM_REGIONS < 1 || NUM_REGIONS > MAX_REGIONS) begin : g_bad_regions
        $error("bus_region_decoder: NUM_REGIONS must be within 1..16");
    end

    logic [NUM_REGIONS-1:0] match;
    logic [3:0]             match_idx;
    logic                   match_hit;
    logic [NUM_REGIONS-1:0] match_onehot;
    logic [WS_W-1:0]        match_ws;

    bus_state_t             state, state_n;
    logic [WS_W-1:0]        cnt, cnt_n;
    logic [NUM_REGIONS-1:0] cs_n;
    logic [3:0]             idx_n;
    logic                   hit_n, ready_n;

    region_match #(
        .ADDR_W      (ADDR_W),
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK),
        .REGION_IO   (REGION_IO)
    ) u_match (
        .addr  (addr),
        .m_io  (m_io),
        .match (match),
        .idx   (match_idx)
    );

    assign match_hit    = |match;
    assign match_onehot = match_hit ? (NUM_REGIONS'(1) << match_idx) : '0;

    always_comb begin
        match_ws = WS_W'(MISS_WS);
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (match_onehot[i]) match_ws = REGION_WS[i];
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cs_n    = cs;
        idx_n   = region_idx;
        hit_n   = hit;
        ready_n = ready;
        // A new cycle may start from idle, or overlap the end of an active one
        if (bus_start && (state == ST_IDLE || (state == ST_ACTIVE && bus_end))) begin
            cs_n  = match_onehot;
            idx_n = match_hit ? match_idx : 4'd0;
            hit_n = match_hit;
            cnt_n = match_ws;
            if (match_ws == '0) begin
                state_n = ST_ACTIVE;
                ready_n = 1'b1;
            end else begin
                state_n = ST_WAIT;
                ready_n = 1'b0;
            end
        end else begin
            case (state)
                ST_WAIT: begin
                    cnt_n = cnt - 1'b1;
                    if (cnt == WS_W'(1)) begin
                        state_n = ST_ACTIVE;
                        ready_n = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (bus_end) begin
                        state_n = ST_IDLE;
                        cs_n    = '0;
                        idx_n   = 4'd0;
                        hit_n   = 1'b0;
                        ready_n = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cs         <= '0;
            region_idx <= 4'd0;
            hit        <= 1'b0;
            ready      <= 1'b0;
        end else if (ce) begin
            state      <= state_n;
            cnt        <= cnt_n;
            cs         <= cs_n;
            region_idx <= idx_n;
            hit        <= hit_n;
            ready      <= ready_n;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_bus_region_decoder.sv
// tb/tb_bus_region_decoder.sv - self-checking bench for bus_region_decoder
module tb_bus_region_decoder;
    import m72_bus_pkg::*;

    localparam int AW = 20, NR = 8, WW = 3, MISS = 1;
    localparam logic [NR-1:0][AW-1:0] BASE = {M72_IO_PORT_BASE, 20'h80000, M72_CHARA_BASE, M72_RAM_BASE,
                                              20'h40000, M72_ROM1_BASE, M72_CHARA_P_BASE, M72_ROM0_BASE};
    localparam logic [NR-1:0][AW-1:0] MASK = {M72_IO_PORT_MASK, 20'hF0000, M72_CHARA_MASK, M72_RAM_MASK,
                                              20'hF0000, M72_ROM1_MASK, M72_CHARA_P_MASK, M72_ROM0_MASK};
    localparam logic [NR-1:0]         IO   = 8'b1000_0000;
    localparam logic [NR-1:0][WW-1:0] WS   = {3'd0, 3'd7, 3'd4, 3'd1, 3'd3, 3'd0, 3'd2, 3'd0};

    logic          clk = 1'b0;
    logic          reset = 1'b1, ce = 1'b1, bus_start = 1'b0, bus_end = 1'b0, m_io = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [NR-1:0] cs;
    logic [3:0]    region_idx;
    logic          hit, ready, busy;

    int total = 0;
    int bad = 0;

    bus_region_decoder #(
        .ADDR_W(AW), .NUM_REGIONS(NR), .WS_W(WW), .REGION_BASE(BASE), .REGION_MASK(MASK),
        .REGION_IO(IO), .REGION_WS(WS), .MISS_WS(MISS)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .bus_start(bus_start), .bus_end(bus_end), .addr(addr),
        .m_io(m_io), .cs(cs), .region_idx(region_idx), .hit(hit), .ready(ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: first window whose masked bits equal the base and whose space matches
    function automatic void model(input logic [AW-1:0] a, input logic mio,
                                  output int ridx, output bit rhit, output int rws);
        ridx = 0; rhit = 0; rws = MISS;
        for (int i = 0; i < NR; i++) begin
            if (!rhit && ((a ^ BASE[i]) & MASK[i]) == 0 && mio != IO[i]) begin
                rhit = 1; ridx = i; rws = int'(WS[i]);
            end
        end
    endfunction

    task automatic run_txn(input logic [AW-1:0] a, input logic mio, input bit noise);
        int ridx, rws;
        bit rhit;
        logic [NR-1:0] ecs;
        model(a, mio, ridx, rhit, rws);
        ecs = '0;
        if (rhit) ecs[ridx] = 1'b1;
        addr = a; m_io = mio; bus_start = 1'b1;
        step();
        bus_start = 1'b0;
        total++;
        if (cs !== ecs || hit !== rhit || region_idx !== 4'(ridx) || busy !== 1'b1 || ready !== (rws == 0)) begin
            bad++;
            $display("FAIL start addr=%05h m_io=%0b: cs=%02h hit=%0b idx=%0d busy=%0b ready=%0b expected cs=%02h hit=%0b idx=%0d busy=1 ready=%0b",
                     a, mio, cs, hit, region_idx, busy, ready, ecs, rhit, ridx, (rws == 0));
        end
        for (int k = 1; k <= rws; k++) begin
            if (noise) begin
                bus_end = 1'($urandom_range(1, 0)); bus_start = 1'($urandom_range(1, 0));
                addr = AW'($urandom); m_io = 1'($urandom_range(1, 0));
            end
            step();
            bus_end = 1'b0; bus_start = 1'b0;
            total++;
            if (ready !== (k == rws) || cs !== ecs || busy !== 1'b1) begin
                bad++;
                $display("FAIL wait addr=%05h k=%0d: ready=%0b cs=%02h busy=%0b expected ready=%0b cs=%02h busy=1",
                         a, k, ready, cs, busy, (k == rws), ecs);
            end
        end
        step();
        total++;
        if (ready !== 1'b1 || cs !== ecs) begin
            bad++;
            $display("FAIL hold addr=%05h: ready=%0b cs=%02h expected ready=1 cs=%02h", a, ready, cs, ecs);
        end
        bus_end = 1'b1;
        step();
        bus_end = 1'b0;
        total++;
        if (cs !== '0 || ready !== 1'b0 || busy !== 1'b0 || hit !== 1'b0 || region_idx !== 4'd0) begin
            bad++;
            $display("FAIL end addr=%05h: cs=%02h ready=%0b busy=%0b hit=%0b idx=%0d expected all 0",
                     a, cs, ready, busy, hit, region_idx);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 1'b1;
        step(); step();
        total++;
        if (cs !== '0 || ready !== 1'b0 || busy !== 1'b0 || hit !== 1'b0 || region_idx !== 4'd0) begin
            bad++;
            $display("FAIL reset: cs=%02h ready=%0b busy=%0b hit=%0b idx=%0d expected all 0",
                     cs, ready, busy, hit, region_idx);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_m72_memory();
        run_txn(20'h01234, 1'b1, 1'b0);
        run_txn(20'hC8010, 1'b1, 1'b0);
        run_txn(20'hA3FFF, 1'b1, 1'b0);
    endtask

    task automatic test_io();
        run_txn(20'h00044, 1'b0, 1'b0);
        run_txn(20'h00044, 1'b1, 1'b0);
    endtask

    task automatic test_miss();
        run_txn(20'hF0044, 1'b1, 1'b0);
        run_txn(20'h00104, 1'b0, 1'b0);
    endtask

    task automatic test_overlap();
        run_txn(20'h40000, 1'b1, 1'b0);
        run_txn(20'h7FFFF, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        addr = 20'h01234; m_io = 1'b1; bus_start = 1'b1;
        step();
        addr = 20'h40010; bus_start = 1'b1; bus_end = 1'b1;
        step();
        total++;
        if (cs !== 8'h04 || ready !== 1'b1 || busy !== 1'b1 || region_idx !== 4'd2) begin
            bad++;
            $display("FAIL b2b_zero: cs=%02h ready=%0b busy=%0b idx=%0d expected cs=04 ready=1 busy=1 idx=2",
                     cs, ready, busy, region_idx);
        end
        addr = 20'hC8010;
        step();
        bus_start = 1'b0; bus_end = 1'b0;
        total++;
        if (cs !== 8'h02 || ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_wait: cs=%02h ready=%0b busy=%0b expected cs=02 ready=0 busy=1", cs, ready, busy);
        end
        step(); step();
        total++;
        if (ready !== 1'b1 || cs !== 8'h02) begin
            bad++;
            $display("FAIL b2b_ready: ready=%0b cs=%02h expected ready=1 cs=02", ready, cs);
        end
        bus_end = 1'b1;
        step();
        bus_end = 1'b0;
        total++;
        if (busy !== 1'b0 || cs !== '0) begin
            bad++;
            $display("FAIL b2b_end: busy=%0b cs=%02h expected busy=0 cs=00", busy, cs);
        end
    endtask

    task automatic test_ce_hold();
        int edges;
        bit done;
        ce = 1'b0; addr = 20'hD0010; m_io = 1'b1; bus_start = 1'b1;
        step();
        total++;
        if (busy !== 1'b0 || cs !== '0) begin
            bad++;
            $display("FAIL ce_idle: busy=%0b cs=%02h expected busy=0 cs=00", busy, cs);
        end
        ce = 1'b1;
        step();
        bus_start = 1'b0;
        edges = 0; done = 0;
        for (int t = 0; t < 60 && !done; t++) begin
            ce = 1'($urandom_range(1, 0));
            if (ce) edges++;
            step();
            total++;
            if (ready !== (edges >= 4) || cs !== 8'h20) begin
                bad++;
                $display("FAIL ce_wait t=%0d: ready=%0b cs=%02h expected ready=%0b cs=20", t, ready, cs, (edges >= 4));
            end
            if (edges >= 4) done = 1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL ce_budget: ready edges=%0d expected 4", edges);
        end
        ce = 1'b1; bus_end = 1'b1;
        step();
        bus_end = 1'b0;
    endtask

    task automatic test_reset_wait();
        addr = 20'hC8010; m_io = 1'b1; bus_start = 1'b1;
        step();
        bus_start = 1'b0;
        ce = 1'b0; reset = 1'b1;
        step();
        total++;
        if (cs !== '0 || ready !== 1'b0 || busy !== 1'b0 || hit !== 1'b0) begin
            bad++;
            $display("FAIL reset_wait: cs=%02h ready=%0b busy=%0b hit=%0b expected all 0", cs, ready, busy, hit);
        end
        reset = 1'b0; ce = 1'b1;
        run_txn(20'h01234, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        int r;
        for (int n = 0; n < 40; n++) begin
            a = AW'($urandom);
            if ($urandom_range(3, 0) != 0) begin
                r = $urandom_range(NR - 1, 0);
                a = (BASE[r] & MASK[r]) | (a & ~MASK[r]);
            end
            run_txn(a, 1'($urandom_range(1, 0)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_m72_memory();
        test_io();
        test_miss();
        test_overlap();
        test_back_to_back();
        test_ce_hold();
        test_reset_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
